// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: samples a VGA output stream (pixel, syncs, blank) in the
// system clock domain. It recovers pixel coordinates, measures the line and
// frame timing, folds every active pixel into a per-frame checksum and raises
// a sticky flag on any timing mismatch.
// Optional feature macro: VGA_MON_ERRCNT_EN adds a saturating count of frames
// that contained a timing error.
module vga_frame_monitor #(
    parameter int H_TOTAL_EXP  = 800,
    parameter int V_TOTAL_EXP  = 525,
    parameter int H_ACTIVE_EXP = 640,
    parameter int V_ACTIVE_EXP = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic        VGA_CLK,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_n,
    input  logic        err_clr,
    output logic        pix_valid,
    output logic [9:0]  pix_col,
    output logic [9:0]  pix_row,
    output logic [23:0] pix_rgb,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic [10:0] h_total,
    output logic [9:0]  v_total,
    output logic [9:0]  active_w,
    output logic [9:0]  active_h,
    output logic [31:0] checksum,
    output logic        timing_err,
    output logic [7:0]  err_count
);
    typedef enum logic {ACQUIRE = 1'b0, FRAME = 1'b1} state_t;

    localparam logic [10:0] HCNT_MAX = 11'h7FF;
    localparam logic [9:0]  CNT_MAX  = 10'h3FF;
    localparam logic [10:0] H_TOT_L  = 11'(H_TOTAL_EXP);
    localparam logic [9:0]  V_TOT_L  = 10'(V_TOTAL_EXP);
    localparam logic [9:0]  H_ACT_L  = 10'(H_ACTIVE_EXP);
    localparam logic [9:0]  V_ACT_L  = 10'(V_ACTIVE_EXP);

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == HCNT_MAX) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    state_t      state_q, state_d;
    logic        vclk_q, hs_q, vs_q, blank_q;
    logic [10:0] hcnt_q, hcnt_d, h_meas_q, h_meas_d;
    logic [9:0]  vcnt_q, vcnt_d, colcnt_q, colcnt_d, rowcnt_q, rowcnt_d;
    logic [9:0]  width_q, width_d;
    logic [31:0] acc_q, acc_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_col_q, pix_col_d, pix_row_q, pix_row_d;
    logic [23:0] pix_rgb_q, pix_rgb_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [10:0] h_total_q, h_total_d;
    logic [9:0]  v_total_q, v_total_d, active_w_q, active_w_d, active_h_q, active_h_d;
    logic [31:0] checksum_q, checksum_d;
    logic        timing_err_q, timing_err_d;
    logic        err_set;

    // Pixel-clock rising edge and sync/blank edges between consecutive ticks
    logic tick, hs_fall, vs_fall, bl_fall;
    assign tick    = VGA_CLK & ~vclk_q;
    assign hs_fall = tick & hs_q & ~VGA_HS;
    assign vs_fall = tick & vs_q & ~VGA_VS;
    assign bl_fall = tick & blank_q & ~VGA_BLANK_n;

    // Next-state: acquisition, per-tick counting, line end then frame end
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        colcnt_d      = colcnt_q;
        rowcnt_d      = rowcnt_q;
        h_meas_d      = h_meas_q;
        width_d       = width_q;
        acc_d         = acc_q;
        pix_valid_d   = 1'b0;
        pix_col_d     = pix_col_q;
        pix_row_d     = pix_row_q;
        pix_rgb_d     = pix_rgb_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        active_w_d    = active_w_q;
        active_h_d    = active_h_q;
        checksum_d    = checksum_q;
        err_set       = 1'b0;
        if (state_q == ACQUIRE) begin
            hcnt_d   = '0;
            vcnt_d   = '0;
            colcnt_d = '0;
            rowcnt_d = '0;
            h_meas_d = '0;
            width_d  = '0;
            acc_d    = '0;
            if (vs_fall) state_d = FRAME;
        end else if (tick) begin
            if (VGA_BLANK_n) begin
                pix_valid_d = 1'b1;
                pix_col_d   = colcnt_q;
                pix_row_d   = rowcnt_q;
                pix_rgb_d   = {VGA_R, VGA_G, VGA_B};
                acc_d       = {acc_q[30:0], acc_q[31]} ^ {8'h00, VGA_R, VGA_G, VGA_B};
                colcnt_d    = sat_inc10(colcnt_q);
                if (colcnt_q >= CNT_MAX - 10'd1) err_set = 1'b1;
            end
            if (bl_fall) begin
                width_d  = colcnt_q;
                colcnt_d = '0;
                rowcnt_d = sat_inc10(rowcnt_q);
                if (colcnt_q != H_ACT_L) err_set = 1'b1;
                if (rowcnt_q >= CNT_MAX - 10'd1) err_set = 1'b1;
            end
            if (hs_fall) begin
                h_meas_d = sat_inc11(hcnt_q);
                hcnt_d   = '0;
                vcnt_d   = sat_inc10(vcnt_q);
                if (vcnt_q >= CNT_MAX - 10'd1) err_set = 1'b1;
            end else begin
                hcnt_d = sat_inc11(hcnt_q);
                if (hcnt_q >= HCNT_MAX - 11'd1) err_set = 1'b1;
            end
            // Frame end sees the line-end results of this same tick
            if (vs_fall) begin
                h_total_d     = h_meas_d;
                v_total_d     = vcnt_d;
                active_w_d    = width_d;
                active_h_d    = rowcnt_d;
                checksum_d    = acc_d;
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
                if (h_total_d != H_TOT_L || v_total_d != V_TOT_L ||
                    active_w_d != H_ACT_L || active_h_d != V_ACT_L) err_set = 1'b1;
                vcnt_d   = '0;
                rowcnt_d = '0;
                colcnt_d = '0;
                acc_d    = '0;
            end
        end
        timing_err_d = err_set | (timing_err_q & ~err_clr);
    end

    // State, sampled inputs, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ACQUIRE;
            vclk_q        <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            blank_q       <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            colcnt_q      <= '0;
            rowcnt_q      <= '0;
            h_meas_q      <= '0;
            width_q       <= '0;
            acc_q         <= '0;
            pix_valid_q   <= 1'b0;
            pix_col_q     <= '0;
            pix_row_q     <= '0;
            pix_rgb_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            active_w_q    <= '0;
            active_h_q    <= '0;
            checksum_q    <= '0;
            timing_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            vclk_q        <= VGA_CLK;
            if (tick) begin
                hs_q    <= VGA_HS;
                vs_q    <= VGA_VS;
                blank_q <= VGA_BLANK_n;
            end
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            colcnt_q      <= colcnt_d;
            rowcnt_q      <= rowcnt_d;
            h_meas_q      <= h_meas_d;
            width_q       <= width_d;
            acc_q         <= acc_d;
            pix_valid_q   <= pix_valid_d;
            pix_col_q     <= pix_col_d;
            pix_row_q     <= pix_row_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            active_w_q    <= active_w_d;
            active_h_q    <= active_h_d;
            checksum_q    <= checksum_d;
            timing_err_q  <= timing_err_d;
        end
    end

`ifdef VGA_MON_ERRCNT_EN
    logic       bad_q;
    logic [7:0] err_count_q;

    // Count frames that saw any timing error; only reset clears the count
    always_ff @(posedge clk) begin
        if (reset) begin
            bad_q       <= 1'b0;
            err_count_q <= '0;
        end else if (state_q == FRAME && vs_fall) begin
            bad_q <= 1'b0;
            if ((bad_q | err_set) && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
        end else if (err_set) begin
            bad_q <= 1'b1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'h00;
`endif

    assign pix_valid   = pix_valid_q;
    assign pix_col     = pix_col_q;
    assign pix_row     = pix_row_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign active_w    = active_w_q;
    assign active_h    = active_h_q;
    assign checksum    = checksum_q;
    assign timing_err  = timing_err_q;
endmodule
